// File: rtl/counter_fsm_param_pkg.sv
// Shared encodings for the counter FSM: state and mode enums.
package counter_fsm_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CNT_UP = 2'b01,
        ST_CNT_DN = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DN     = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

endpackage

// File: rtl/tick_divider.sv
// Single-clock step divider: one-cycle tick every DIV_COUNT enabled cycles; en=0 clears the count.
module tick_divider #(
    parameter int DIV_COUNT = 1500000,
    parameter int DIV_W     = 24
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_COUNT - 1);

    logic [DIV_W-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_fsm_param.sv
// Button-started up/down/bounce LED counter with Mealy done pulse.
// Optional go debounce filter enabled by defining GO_DEBOUNCE_EN.
module counter_fsm_param
    import counter_fsm_param_pkg::*;
#(
    parameter int CNT_W           = 4,
    parameter int MAX_COUNT       = 15,
    parameter int DIV_COUNT       = 1500000,
    parameter int DIV_W           = 24,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst_btn,
    input  logic             go_btn,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] led,
    output logic             busy,
    output logic             done_sig
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic go_sync1_q, go_sync2_q, go_lvl, go_prev_q, go_pulse_q;

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            go_sync1_q <= 1'b0;
            go_sync2_q <= 1'b0;
            go_prev_q  <= 1'b0;
            go_pulse_q <= 1'b0;
        end else begin
            go_sync1_q <= ~go_btn;
            go_sync2_q <= go_sync1_q;
            go_prev_q  <= go_lvl;
            go_pulse_q <= go_lvl & ~go_prev_q;
        end
    end

`ifdef GO_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             deb_q;
    logic [DEB_W-1:0] deb_cnt_q;

    // The debounced level only follows the synchroniser after an unbroken run of differing samples.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else if (go_sync2_q == deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_q     <= go_sync2_q;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    assign go_lvl = deb_q;
`else
    assign go_lvl = go_sync2_q;
`endif

    state_e           state_q;
    logic [CNT_W-1:0] led_q;
    logic             busy_q;
    logic             bounce_q;
    logic             tick;

    tick_divider #(
        .DIV_COUNT (DIV_COUNT),
        .DIV_W     (DIV_W)
    ) u_div (
        .clk     (clk),
        .rst_btn (rst_btn),
        .en      (state_q != ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            state_q  <= ST_IDLE;
            led_q    <= '0;
            busy_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_pulse_q) begin
                        busy_q <= 1'b1;
                        case (mode_e'(mode))
                            MODE_DN: begin
                                state_q  <= ST_CNT_DN;
                                led_q    <= MAX_C;
                                bounce_q <= 1'b0;
                            end
                            MODE_BOUNCE: begin
                                state_q  <= ST_CNT_UP;
                                led_q    <= '0;
                                bounce_q <= 1'b1;
                            end
                            default: begin
                                state_q  <= ST_CNT_UP;
                                led_q    <= '0;
                                bounce_q <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_CNT_UP: begin
                    if (tick) begin
                        if (led_q < MAX_C) begin
                            led_q <= led_q + 1'b1;
                        end else if (bounce_q) begin
                            state_q <= ST_CNT_DN;
                            led_q   <= MAX_C - 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_CNT_DN: begin
                    if (tick) begin
                        if (led_q != '0) begin
                            led_q <= led_q - 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done_sig = rst_btn && tick &&
                      (((state_q == ST_CNT_UP) && (led_q == MAX_C) && !bounce_q) ||
                       ((state_q == ST_CNT_DN) && (led_q == '0)));

endmodule

// File: tb/tb_counter_fsm_param.sv
// Directed self-checking bench for counter_fsm_param (CNT_W=4, MAX_COUNT=5, DIV_COUNT=4, DEBOUNCE_CYCLES=8).
module tb_counter_fsm_param;

    localparam int CNT_W = 4;
    localparam int MAX_C = 5;
    localparam int DIV   = 4;
    localparam int DEB   = 8;
`ifdef GO_DEBOUNCE_EN
    localparam int START_LAT = 4 + DEB;
`else
    localparam int START_LAT = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_btn = 1'b0;
    logic             go_btn = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] led;
    logic             busy;
    logic             done_sig;

    int checks   = 0;
    int failures = 0;

    counter_fsm_param #(
        .CNT_W           (CNT_W),
        .MAX_COUNT       (MAX_C),
        .DIV_COUNT       (DIV),
        .DIV_W           (4),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst_btn  (rst_btn),
        .go_btn   (go_btn),
        .mode     (mode),
        .led      (led),
        .busy     (busy),
        .done_sig (done_sig)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press go, confirm the state leaves IDLE exactly START_LAT edges later, then release.
    task automatic start_run(input logic [1:0] m, input int exp_led);
        mode   = m;
        go_btn = 1'b0;
        step(START_LAT - 1);
        chk("busy_before_start", busy, 1'b0);
        step(1);
        chk("busy_at_start", busy, 1'b1);
        chk("led_at_start", led, exp_led);
        go_btn = 1'b1;
    endtask

    initial begin
        // Power-on reset
        step(1);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done_sig, 1'b0);
        step(2);
        rst_btn = 1'b1;
        step(2);

        // Up run: 0..5, done at tick with led=5
        start_run(2'b00, 0);
        step(4);  chk("up_led1", led, 1);
        step(12); chk("up_led4", led, 4);
        step(4);  chk("up_led5", led, 5);
        chk("up_no_done_early", done_sig, 1'b0);
        step(3);  chk("up_done", done_sig, 1'b1);
        chk("up_done_led", led, 5);
        step(1);  chk("up_idle", busy, 1'b0);
        chk("up_hold_led", led, 5);
        chk("up_done_once", done_sig, 1'b0);
        step(6);  chk("up_idle_hold", led, 5);

        // Mid-idle reset, 3 clocks
        rst_btn = 1'b0;
        step(1);
        chk("idle_rst_led", led, 0);
        chk("idle_rst_busy", busy, 1'b0);
        chk("idle_rst_done", done_sig, 1'b0);
        step(2);
        rst_btn = 1'b1;
        step(2);

        // Down run: 5..0, done at tick with led=0
        start_run(2'b01, 5);
        step(4);  chk("dn_led4", led, 4);
        step(16); chk("dn_led0", led, 0);
        step(3);  chk("dn_done", done_sig, 1'b1);
        step(1);  chk("dn_idle", busy, 1'b0);
        chk("dn_hold_led", led, 0);

        // Bounce run: 0..5..0, no done at the peak
        step(3);
        start_run(2'b10, 0);
        step(20); chk("bn_peak", led, 5);
        step(3);  chk("bn_no_done_peak", done_sig, 1'b0);
        step(1);  chk("bn_turn_led", led, 4);
        chk("bn_turn_busy", busy, 1'b1);
        step(16); chk("bn_led0", led, 0);
        step(3);  chk("bn_done", done_sig, 1'b1);
        step(1);  chk("bn_idle", busy, 1'b0);

        // Re-press and mode change mid-run are ignored; reset mid-count aborts silently
        step(3);
        start_run(2'b00, 0);
        step(8);  chk("ign_led2", led, 2);
        go_btn = 1'b0;
        mode   = 2'b01;
        step(4);  chk("ign_led3", led, 3);
        chk("ign_busy", busy, 1'b1);
        rst_btn = 1'b0;
        go_btn  = 1'b1;
        chk("ign_rst_no_done", done_sig, 1'b0);
        step(1);
        chk("midrst_led", led, 0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done_sig, 1'b0);
        step(2);
        rst_btn = 1'b1;
        mode    = 2'b00;
        step(10);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_led", led, 0);

        // Reserved mode behaves as up
        start_run(2'b11, 0);
        step(4); chk("rsvd_led1", led, 1);
        rst_btn = 1'b0;
        step(2);
        rst_btn = 1'b1;
        step(2);

`ifdef GO_DEBOUNCE_EN
        // A 3-clock glitch never passes the filter
        go_btn = 1'b0;
        step(3);
        go_btn = 1'b1;
        step(20);
        chk("deb_glitch_busy", busy, 1'b0);
        start_run(2'b00, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
